// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO plus IDLE/DRIVE/RESP sequencer feeding a combinational ALU
// Optional build macro: ILLEGAL_OP_CHECK_EN (reject op codes outside 2..11 without driving the ALU)
module alu_cmd_sequencer #(
  parameter int DEPTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_ctrl,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [3:0] alu_ctrl,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_s,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t state_q, state_d;

  logic [19:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;
  logic [19:0]   head;
  logic          head_illegal;

  logic [3:0] alu_ctrl_q, alu_ctrl_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       err_q, err_d;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state_q == IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr_q];

`ifdef ILLEGAL_OP_CHECK_EN
  assign head_illegal = (head[19:16] < 4'd2) || (head[19:16] > 4'd11);
`else
  assign head_illegal = 1'b0;
`endif

  // Command storage; contents need no reset because count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {cmd_ctrl, cmd_a, cmd_b};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_ctrl_q  <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_ctrl_q  <= alu_ctrl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Next-state: rejected ops skip DRIVE, the response waits in RESP for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = head_illegal ? RESP : DRIVE;
      DRIVE:   if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load ALU on pop, count down the settle window, capture alu_s.
  always_comb begin
    alu_ctrl_d  = alu_ctrl_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            err_d       = 1'b1;
          end else begin
            alu_ctrl_d = head[19:16];
            alu_a_d    = head[15:8];
            alu_b_d    = head[7:0];
            cnt_d      = SETTLE_INIT;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_s;
          err_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign alu_ctrl  = alu_ctrl_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - scoreboard bench for alu_cmd_sequencer with a behavioural ALU
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [3:0] cmd_ctrl, alu_ctrl;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_s, rsp_data;

  logic       c3_cmd_valid, c3_cmd_ready, c3_rsp_valid, c3_rsp_ready, c3_rsp_err, c3_busy;
  logic [3:0] c3_cmd_ctrl, c3_alu_ctrl;
  logic [7:0] c3_cmd_a, c3_cmd_b, c3_alu_a, c3_alu_b, c3_alu_s, c3_rsp_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  function automatic logic [7:0] alu_model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      4'd2:    return a;
      4'd3:    return a + 8'd1;
      4'd4:    return a - 8'd1;
      4'd5:    return (a > 8'd127) ? a - 8'd1 : a;
      4'd6:    return ~(a | b);
      4'd7:    return a ^ b;
      4'd8:    return ~(a ^ b);
      4'd9:    return (a > b) ? 8'd1 : 8'd0;
      4'd10:   return (a < b) ? 8'd1 : 8'd0;
      4'd11:   return (a == b) ? 8'd1 : 8'd0;
      default: return a ^ b ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [8:0] expect_rsp(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
`ifdef ILLEGAL_OP_CHECK_EN
    if (c < 4'd2 || c > 4'd11) return 9'h100;
`endif
    return {1'b0, alu_model(c, a, b)};
  endfunction

  assign alu_s    = alu_model(alu_ctrl, alu_a, alu_b);
  assign c3_alu_s = alu_model(c3_alu_ctrl, c3_alu_a, c3_alu_b);

  alu_cmd_sequencer #(.DEPTH(4), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ctrl(cmd_ctrl), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  alu_cmd_sequencer #(.DEPTH(4), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready),
    .cmd_ctrl(c3_cmd_ctrl), .cmd_a(c3_cmd_a), .cmd_b(c3_cmd_b),
    .alu_ctrl(c3_alu_ctrl), .alu_a(c3_alu_a), .alu_b(c3_alu_b), .alu_s(c3_alu_s),
    .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_data(c3_rsp_data),
    .rsp_err(c3_rsp_err), .busy(c3_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at 1 time unit after a rising edge; returns 1 unit after the accepting edge.
  task automatic push1(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    int budget = 0;
    cmd_valid = 1'b1; cmd_ctrl = c; cmd_a = a; cmd_b = b;
    while (!cmd_ready && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(expect_rsp(c, a, b));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic push3(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    c3_cmd_valid = 1'b1; c3_cmd_ctrl = c; c3_cmd_a = a; c3_cmd_b = b;
    check("c3_push_ready", 32'(c3_cmd_ready), 32'd1);
    @(posedge clk); #1;
    c3_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 2000) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain_done", 32'((exp_q.size() == 0) && !busy), 32'd1);
  endtask

  function automatic logic [7:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 8'd0;
      1:       return 8'd127;
      2:       return 8'd128;
      3:       return 8'd255;
      default: return 8'($urandom);
    endcase
  endfunction

  // Response monitor: pops the scoreboard on each handshake and checks stability under stall.
  logic       held;
  logic [8:0] held_v;
  logic [8:0] mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", 32'({rsp_err, rsp_data}), 32'(held_v));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", 32'({rsp_err, rsp_data}), 32'(mon_e));
        end
        held = 1'b0;
      end else if (rsp_valid) begin
        held   = 1'b1;
        held_v = {rsp_err, rsp_data};
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint t0, t1;
    logic   done;
    cmd_valid = 1'b0; cmd_ctrl = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    c3_cmd_valid = 1'b0; c3_cmd_ctrl = '0; c3_cmd_a = '0; c3_cmd_b = '0; c3_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'({rsp_err, rsp_data}), 32'd0);
    check("rst_alu", 32'({alu_ctrl, alu_a, alu_b}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single increment with wrap, latency SETTLE_CYCLES=1
    push1(4'd3, 8'hFF, 8'h00);
    @(posedge clk); #1;
    check("t1_alu_a", 32'(alu_a), 32'hFF);
    check("t1_alu_ctrl", 32'(alu_ctrl), 32'd3);
    check("t1_early_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_rsp_data", 32'(rsp_data), 32'h00);
    @(posedge clk); #1;
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_valid_low", 32'(rsp_valid), 32'd0);

    // ordered compare results
    push1(4'd9, 8'd200, 8'd100);
    push1(4'd10, 8'd200, 8'd100);
    push1(4'd5, 8'd130, 8'd0);
    wait_drain();

    // backpressure: DEPTH+1 back-to-back accepts, then full
    rsp_ready = 1'b0;
    t0 = $time;
    for (int i = 0; i < 5; i++) push1(4'(i + 2), 8'($urandom), 8'($urandom));
    t1 = $time;
    check("bp_back_to_back", 32'((t1 - t0) / 10), 32'd5);
    check("bp_full", 32'(cmd_ready), 32'd0);
    repeat (8) begin @(posedge clk); #1; end
    check("bp_still_full", 32'(cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    wait_drain();

    // SETTLE_CYCLES=3 instance
    push3(4'd7, 8'hA5, 8'h0F);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("s3_alu_stable", 32'({c3_alu_ctrl, c3_alu_a, c3_alu_b}), 32'h7A50F);
      check("s3_not_yet", 32'(c3_rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    check("s3_valid", 32'(c3_rsp_valid), 32'd1);
    check("s3_data", 32'({c3_rsp_err, c3_rsp_data}), 32'h0AA);
    @(posedge clk); #1;
    check("s3_idle", 32'(c3_busy), 32'd0);

    // unassigned op code 12
    push1(4'd2, 8'h33, 8'h44);
    wait_drain();
    push1(4'd12, 8'd5, 8'd0);
    @(posedge clk); #1;
`ifdef ILLEGAL_OP_CHECK_EN
    check("ill_valid", 32'(rsp_valid), 32'd1);
    check("ill_err_data", 32'({rsp_err, rsp_data}), 32'h100);
    check("ill_alu_kept", 32'({alu_ctrl, alu_a}), 32'h233);
`else
    check("ill_alu_loaded", 32'({alu_ctrl, alu_a}), 32'hC05);
    check("ill_not_yet", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("ill_valid", 32'(rsp_valid), 32'd1);
    check("ill_err", 32'(rsp_err), 32'd0);
`endif
    wait_drain();

    // randomized traffic with random consumer stalls
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          push1(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rsp_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    rsp_ready = 1'b1;
    wait_drain();

    // asynchronous reset during DRIVE with two commands queued
    push3(4'd2, 8'h11, 8'h00);
    push3(4'd3, 8'h22, 8'h00);
    push3(4'd4, 8'h33, 8'h00);
    check("rr_busy_before", 32'(c3_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_alu", 32'({c3_alu_ctrl, c3_alu_a, c3_alu_b}), 32'd0);
    check("rr_rsp", 32'({c3_rsp_valid, c3_rsp_err, c3_rsp_data}), 32'd0);
    check("rr_cmd_ready", 32'(c3_cmd_ready), 32'd1);
    check("rr_busy", 32'(c3_busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("rr_no_rsp", 32'({c3_rsp_valid, c3_busy}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
